// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: capture pattern, BYPASS opcode helper and TAP enable bundle.
package jtag_pkg;

  localparam logic [1:0] CAP_LSB = 2'b01;

  typedef struct packed {
    logic test_logic_reset;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_en_t;

  typedef enum logic [1:0] {
    SR_HOLD,
    SR_TLR,
    SR_CAPTURE,
    SR_SHIFT
  } sr_op_t;

  // All-ones BYPASS opcode for the given width, returned right-aligned in 8 bits
  function automatic logic [7:0] all_ones(input int unsigned width);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < width) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jtag_ir_decode.sv
// Opcode to one-hot decode plus implemented-opcode check; shared with the DR-select mux.
module jtag_ir_decode #(
  parameter int unsigned                  IR_WIDTH   = 4,
  parameter logic [(2**IR_WIDTH)-1:0]     VALID_MASK = '1
) (
  input  logic [IR_WIDTH-1:0]        opcode,
  output logic [(2**IR_WIDTH)-1:0]   onehot,
  output logic                       valid
);

  always_comb begin
    onehot         = '0;
    onehot[opcode] = 1'b1;
  end

  assign valid = VALID_MASK[opcode];

endmodule

// File: rtl/jtag_ir_reg.sv
// N-bit JTAG instruction register: capture/shift path, guarded update path, decode and change strobe.
module jtag_ir_reg
  import jtag_pkg::*;
#(
  parameter int unsigned              IR_WIDTH   = 4,
  parameter logic [IR_WIDTH-1:0]      RST_INSTR  = '1,
  parameter logic [(2**IR_WIDTH)-1:0] VALID_MASK = '1
) (
  input  logic                      tck,
  input  logic                      reset,
  input  logic                      test_logic_reset,
  input  logic                      capture_ir,
  input  logic                      shift_ir,
  input  logic                      update_ir,
  input  logic                      tdi,
  input  logic [IR_WIDTH-3:0]       status_in,
  output logic                      tdo,
  output logic [IR_WIDTH-1:0]       ir_out,
  output logic [(2**IR_WIDTH)-1:0]  instr_onehot,
  output logic                      ir_changed
);

  localparam logic [7:0]          BYP8   = all_ones(IR_WIDTH);
  localparam logic [IR_WIDTH-1:0] BYPASS = BYP8[IR_WIDTH-1:0];

  logic [IR_WIDTH-1:0]      sr;
  logic [IR_WIDTH-1:0]      sr_next;
  logic [IR_WIDTH-1:0]      ir_next;
  logic [IR_WIDTH-1:0]      cap_val;
  logic [(2**IR_WIDTH)-1:0] sr_onehot;
  logic                     sr_valid;
  logic                     ir_valid;
  logic                     unused_ok;
  tap_en_t                  en;
  sr_op_t                   sr_op;

  assign en = '{test_logic_reset: test_logic_reset, capture_ir: capture_ir,
                shift_ir: shift_ir, update_ir: update_ir};

  // A 2-bit IR has no room for status; the port is then present but ignored
  if (IR_WIDTH > 2) begin : g_cap_status
    assign cap_val = {status_in, CAP_LSB};
  end else begin : g_cap_plain
    assign cap_val = CAP_LSB;
  end

  jtag_ir_decode #(.IR_WIDTH(IR_WIDTH), .VALID_MASK(VALID_MASK)) u_sr_dec (
    .opcode (sr),
    .onehot (sr_onehot),
    .valid  (sr_valid)
  );

  jtag_ir_decode #(.IR_WIDTH(IR_WIDTH), .VALID_MASK(VALID_MASK)) u_ir_dec (
    .opcode (ir_out),
    .onehot (instr_onehot),
    .valid  (ir_valid)
  );

  assign unused_ok = ^{sr_onehot, ir_valid, status_in};

  always_comb begin
    sr_op = SR_HOLD;
    if (en.test_logic_reset)  sr_op = SR_TLR;
    else if (en.capture_ir)   sr_op = SR_CAPTURE;
    else if (en.shift_ir)     sr_op = SR_SHIFT;

    sr_next = sr;
    unique case (sr_op)
      SR_TLR:     sr_next = RST_INSTR;
      SR_CAPTURE: sr_next = cap_val;
      SR_SHIFT:   sr_next = {tdi, sr[IR_WIDTH-1:1]};
      default:    sr_next = sr;
    endcase

    // Update reads sr before this edge, so a concurrent capture/shift does not leak in
    ir_next = ir_out;
    if (en.test_logic_reset) ir_next = RST_INSTR;
    else if (en.update_ir)   ir_next = sr_valid ? sr : BYPASS;
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      sr         <= RST_INSTR;
      ir_out     <= RST_INSTR;
      ir_changed <= 1'b0;
    end else begin
      sr         <= sr_next;
      ir_out     <= ir_next;
      ir_changed <= (ir_next != ir_out);
    end
  end

  assign tdo = sr[0];

endmodule

// File: tb/tb_jtag_ir_reg.sv
// Scoreboard bench for jtag_ir_reg: directed TAP sequences plus random enables against a value-level model.
module tb_jtag_ir_reg;

  localparam logic [15:0] MASK = 16'hFFDF;

  logic        tck = 1'b0;
  logic        reset = 1'b1;
  logic        test_logic_reset = 1'b0;
  logic        capture_ir = 1'b0;
  logic        shift_ir = 1'b0;
  logic        update_ir = 1'b0;
  logic        tdi = 1'b0;
  logic [1:0]  status_in = 2'b00;
  logic        tdo;
  logic [3:0]  ir_out;
  logic [15:0] instr_onehot;
  logic        ir_changed;

  jtag_ir_reg #(.IR_WIDTH(4), .RST_INSTR(4'hF), .VALID_MASK(MASK)) dut (
    .tck              (tck),
    .reset            (reset),
    .test_logic_reset (test_logic_reset),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir),
    .tdi              (tdi),
    .status_in        (status_in),
    .tdo              (tdo),
    .ir_out           (ir_out),
    .instr_onehot     (instr_onehot),
    .ir_changed       (ir_changed)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [3:0]  ir;
    logic [15:0] oh;
    logic        ch;
    logic        tdo;
    int          step_no;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_cnt = 0;

  // Model state as plain integers
  int m_sr = 15;
  int m_ir = 15;

  task automatic check(input string name, input int act, input int req, input int sn);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, required %0h", name, sn, act, req);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge tck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ir_out",       int'(ir_out),       int'(e.ir),  e.step_no);
        check("instr_onehot", int'(instr_onehot), int'(e.oh),  e.step_no);
        check("ir_changed",   int'(ir_changed),   int'(e.ch),  e.step_no);
        check("tdo",          int'(tdo),          int'(e.tdo), e.step_no);
      end
    end
  end

  task automatic step(input bit r, input bit tlr, input bit cap, input bit sh,
                      input bit upd, input bit t, input int st);
    exp_t e;
    int   n_sr;
    int   n_ir;
    bit   n_ch;
    @(negedge tck);
    reset = r; test_logic_reset = tlr; capture_ir = cap; shift_ir = sh;
    update_ir = upd; tdi = t; status_in = 2'(st);
    if (r) begin
      n_sr = 15; n_ir = 15; n_ch = 0;
    end else begin
      if (tlr)      n_sr = 15;
      else if (cap) n_sr = st * 4 + 1;
      else if (sh)  n_sr = (m_sr / 2) + (t ? 8 : 0);
      else          n_sr = m_sr;
      if (tlr)      n_ir = 15;
      else if (upd) n_ir = ((MASK >> m_sr) & 16'd1) != 0 ? m_sr : 15;
      else          n_ir = m_ir;
      n_ch = (n_ir != m_ir);
    end
    m_sr = n_sr;
    m_ir = n_ir;
    step_cnt++;
    e.ir = 4'(n_ir); e.oh = 16'(1 << n_ir); e.ch = n_ch; e.tdo = n_sr[0];
    e.step_no = step_cnt;
    exp_q.push_back(e);
  endtask

  task automatic shift_in(input int val, input int nbits);
    for (int i = 0; i < nbits; i++) step(0, 0, 0, 1, 0, ((val >> i) & 1) != 0, 0);
  endtask

  initial begin
    // Reset for two cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Capture status 2'b10 then shift out four bits
    step(0, 0, 1, 0, 0, 0, 2);
    shift_in(0, 4);
    // Load opcode 2 and update
    step(0, 0, 1, 0, 0, 0, 0);
    shift_in(2, 4);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Re-update with the same value: no change pulse
    step(0, 0, 0, 0, 1, 0, 0);
    // Illegal opcode 5 substitutes BYPASS, then again with ir_out already 15
    shift_in(5, 4);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Back to 2, then test_logic_reset after two shift cycles, then update without shift
    shift_in(2, 4);
    step(0, 0, 0, 0, 1, 0, 0);
    shift_in(3, 2);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Update concurrent with shift and with capture uses the pre-edge sr
    shift_in(9, 4);
    step(0, 0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 0, 1, 0, 3);
    // Reset mid-shift discards the partial shift
    shift_in(6, 2);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    // Random enables
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge tck);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
